muldiv_seq: RTL

Sequencer for the multicycle CPU's multiply and divide units. It accepts one MULT/DIV request from the main control unit, checks the divisor for zero, and pulses start to the selected core. It then waits for that core's completion, writes HI/LO through the Mult_Div source mux, and returns a one-cycle done. While busy it stalls the main control unit, and it reports divide-by-zero and (optionally) watchdog timeout as exceptions.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_seq_if.sv | 42 ++++
 rtl/muldiv_watchdog.sv | 39 +++
 rtl/muldiv_seq.sv | 138 +++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
// Shared definitions for the multiply/divide sequencer slice.
//   state_e  : sequencer FSM states
//   OP_MULT  : op encoding for a multiply request
//   OP_DIV   : op encoding for a divide request
package muldiv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    WRITE,
    EXC,
    TMO
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if
// Bundles the request/completion handshake between the main control unit,
// the mult/div cores, the HI/LO register file and the sequencer.
//   req, op, operand_b     : request from the control unit
//   mult_done, div_done    : completion strobes from the cores
//   mult_start, div_start  : start pulses to the cores
//   mult_div_sel           : HI/LO source mux select (0 = mult, 1 = div)
//   hi_write, lo_write     : HI/LO write enables
//   busy, done             : stall and completion back to the control unit
//   div_zero_exc           : divide-by-zero exception pulse
//   timeout_err            : watchdog exception pulse
// modport slave is the sequencer's view, master is the surrounding datapath.
interface muldiv_seq_if;

  logic        req;
  logic        op;
  logic [31:0] operand_b;
  logic        mult_done;
  logic        div_done;
  logic        mult_start;
  logic        div_start;
  logic        mult_div_sel;
  logic        hi_write;
  logic        lo_write;
  logic        busy;
  logic        done;
  logic        div_zero_exc;
  logic        timeout_err;

  modport slave (
    input  req, op, operand_b, mult_done, div_done,
    output mult_start, div_start, mult_div_sel, hi_write, lo_write,
           busy, done, div_zero_exc, timeout_err
  );

  modport master (
    output req, op, operand_b, mult_done, div_done,
    input  mult_start, div_start, mult_div_sel, hi_write, lo_write,
           busy, done, div_zero_exc, timeout_err
  );

endinterface

// File: rtl/muldiv_watchdog.sv
// muldiv_watchdog
// Counts cycles spent waiting on a core and flags the last allowed cycle.
// Only instantiated when MULDIV_TIMEOUT_EN is defined.
//   clock  : system clock, rising edge
//   reset  : asynchronous, active-low
//   clear  : zero the counter (held while the core is being started)
//   enable : count this cycle (high while waiting on the core)
//   expire : high on the MAX_WAIT-th enabled cycle since clear
module muldiv_watchdog #(
  parameter int MAX_WAIT = 40
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  // Wait-cycle counter; clear takes priority so a fresh start always
  // begins from zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // The first enabled cycle sees count 0, so count MAX_WAIT-1 marks the
  // MAX_WAIT-th waiting cycle.
  assign expire = enable && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq
// Sequences one MULT/DIV operation: checks the divisor for zero, pulses
// start to the selected core, waits for its completion, writes HI/LO and
// returns a one-cycle done. Stalls the control unit via busy meanwhile.
//   clock : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : muldiv_seq_if.slave (request, core handshake, HI/LO control,
//           busy/done and exception pulses)
// Parameter MAX_WAIT: cycles allowed in WAIT before a timeout.
// Optional feature macro MULDIV_TIMEOUT_EN: adds the watchdog and the TMO
// path; without it WAIT waits indefinitely and timeout_err stays 0.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int MAX_WAIT = 40
) (
  input logic         clock,
  input logic         reset,
  muldiv_seq_if.slave bus
);

  state_e state;
  state_e state_next;
  logic   op_q;

  logic mult_start;
  logic div_start;
  logic hi_write;
  logic lo_write;
  logic done;
  logic div_zero_exc;
  logic timeout_err;
  logic sel_done;

`ifdef MULDIV_TIMEOUT_EN
  logic wd_expire;

  muldiv_watchdog #(
    .MAX_WAIT(MAX_WAIT)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == START),
    .enable (state == WAIT),
    .expire (wd_expire)
  );
`else
  // MAX_WAIT only matters when the watchdog is built in.
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT > 0);
`endif

  // State register plus the latched op; op_q only moves on an accepted
  // request so the HI/LO mux select is stable through WRITE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= OP_MULT;
    end else begin
      state <= state_next;
      if (state == IDLE && bus.req) begin
        op_q <= bus.op;
      end
    end
  end

  // Next-state and Moore outputs. Only the selected core's done is looked
  // at, and only in WAIT; done beats the watchdog when both hit together.
  always_comb begin
    state_next   = state;
    mult_start   = 1'b0;
    div_start    = 1'b0;
    hi_write     = 1'b0;
    lo_write     = 1'b0;
    done         = 1'b0;
    div_zero_exc = 1'b0;
    timeout_err  = 1'b0;
    sel_done     = (op_q == OP_DIV) ? bus.div_done : bus.mult_done;
    case (state)
      IDLE: begin
        if (bus.req) begin
          if (bus.op == OP_DIV && bus.operand_b == 32'd0) begin
            state_next = EXC;
          end else begin
            state_next = START;
          end
        end
      end
      START: begin
        mult_start = (op_q == OP_MULT);
        div_start  = (op_q == OP_DIV);
        state_next = WAIT;
      end
      WAIT: begin
        if (sel_done) begin
          state_next = WRITE;
        end
`ifdef MULDIV_TIMEOUT_EN
        else if (wd_expire) begin
          state_next = TMO;
        end
`endif
      end
      WRITE: begin
        hi_write   = 1'b1;
        lo_write   = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      EXC: begin
        div_zero_exc = 1'b1;
        done         = 1'b1;
        state_next   = IDLE;
      end
`ifdef MULDIV_TIMEOUT_EN
      TMO: begin
        timeout_err = 1'b1;
        done        = 1'b1;
        state_next  = IDLE;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.mult_start   = mult_start;
  assign bus.div_start    = div_start;
  assign bus.hi_write     = hi_write;
  assign bus.lo_write     = lo_write;
  assign bus.done         = done;
  assign bus.div_zero_exc = div_zero_exc;
  assign bus.timeout_err  = timeout_err;
  assign bus.busy         = (state != IDLE);
  assign bus.mult_div_sel = op_q;

endmodule
